// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array job sequencer.
package systolic_pkg;

    localparam int M_DEF     = 4;
    localparam int N_DEF     = 4;
    localparam int K_MAX_DEF = 256;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        DONE
    } ctrl_state_t;

    // Wavefront drain: read latency + lane skew + PE latency collapses to M+N.
    function automatic int drain_len(input int m, input int n);
        return m + n;
    endfunction

endpackage

// File: rtl/systolic_array_ctrl_skew.sv
// skew_shift: W-deep valid shift register; tap i is din delayed by 1+i cycles.
module skew_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] taps
);

    // NOTE: synchronous active-low reset; clr flushes the wavefront on abort.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            taps <= '0;
        end else begin
            taps <= W'({taps, din});
        end
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the MxN systolic MAC array: clear, feed K operands, drain, capture.
// Optional cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter  int M     = M_DEF,
    parameter  int N     = N_DEF,
    parameter  int K_MAX = K_MAX_DEF,
    localparam int KW    = $clog2(K_MAX + 1),
    localparam int AW    = $clog2(K_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [KW-1:0] k_len,
    input  logic          abort,
    output logic          arr_clear,
    output logic          op_rd_en,
    output logic [AW-1:0] op_rd_addr,
    output logic [M-1:0]  a_lane_valid,
    output logic [N-1:0]  b_lane_valid,
    output logic          res_capture,
    output logic          busy,
    output logic          done_valid,
    input  logic          done_ready,
    output logic          done_err,
    output logic [31:0]   perf_cycles
);

    localparam int            DL      = drain_len(M, N);
    localparam int            DW      = $clog2(DL);
    localparam logic [KW-1:0] K_MAX_V = KW'(K_MAX);

    ctrl_state_t   state;
    logic [KW-1:0] k_eff;
    logic          err;
    logic [DW-1:0] drain_cnt;
    logic          abort_hit;

    assign abort_hit   = abort && (state != IDLE);
    assign start_ready = rst && (state == IDLE);
    assign busy        = rst && (state != IDLE);

    // NOTE: every register here uses <= so all next-state decisions see the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            k_eff       <= '0;
            err         <= 1'b0;
            drain_cnt   <= '0;
            arr_clear   <= 1'b0;
            op_rd_en    <= 1'b0;
            op_rd_addr  <= '0;
            res_capture <= 1'b0;
            done_valid  <= 1'b0;
            done_err    <= 1'b0;
        end else if (abort_hit) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            arr_clear   <= 1'b1;
            op_rd_en    <= 1'b0;
            op_rd_addr  <= '0;
            res_capture <= 1'b0;
            done_valid  <= 1'b0;
            done_err    <= 1'b0;
        end else begin
            arr_clear   <= 1'b0;
            res_capture <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state     <= CLEAR;
                        arr_clear <= 1'b1;
                        k_eff     <= (k_len > K_MAX_V) ? K_MAX_V : k_len;
                        err       <= (k_len > K_MAX_V);
                    end
                end
                CLEAR: begin
                    if (k_eff == '0) begin
                        state <= DRAIN;
                    end else begin
                        state    <= FEED;
                        op_rd_en <= 1'b1;
                    end
                end
                FEED: begin
                    if (KW'(op_rd_addr) == k_eff - 1'b1) begin
                        state      <= DRAIN;
                        op_rd_en   <= 1'b0;
                        op_rd_addr <= '0;
                    end else begin
                        op_rd_addr <= op_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(DL - 1)) begin
                        state       <= CAPTURE;
                        drain_cnt   <= '0;
                        res_capture <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    state      <= DONE;
                    done_valid <= 1'b1;
                    done_err   <= err;
                end
                DONE: begin
                    if (done_ready) begin
                        state      <= IDLE;
                        done_valid <= 1'b0;
                        done_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    skew_shift #(.W(M)) u_skew_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort_hit),
        .din  (op_rd_en),
        .taps (a_lane_valid)
    );

    skew_shift #(.W(N)) u_skew_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort_hit),
        .din  (op_rd_en),
        .taps (b_lane_valid)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_inc;

    assign perf_inc = (perf_cnt == '1) ? perf_cnt : perf_cnt + 1'b1;

    // Counts the accept cycle through the done handshake cycle inclusive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else if (abort_hit) begin
            perf_cnt <= '0;
        end else if (state == IDLE) begin
            if (start_valid) begin
                perf_cnt <= 32'd1;
            end
        end else if (state == DONE && done_ready) begin
            perf_cycles <= perf_inc;
            perf_cnt    <= '0;
        end else begin
            perf_cnt <= perf_inc;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: timing model per cycle plus address/done scoreboards.
module tb_systolic_array_ctrl;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int AW    = $clog2(K_MAX);
    localparam logic [13:0] IDLE_VEC = 14'b10_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          arr_clear;
    logic          op_rd_en;
    logic [AW-1:0] op_rd_addr;
    logic [M-1:0]  a_lane_valid;
    logic [N-1:0]  b_lane_valid;
    logic          res_capture;
    logic          busy;
    logic          done_valid;
    logic          done_ready;
    logic          done_err;
    logic [31:0]   perf_cycles;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [AW-1:0] addr_q[$];
    logic          err_q[$];

    typedef struct {
        int   k;
        int   delay;
        logic exp_err;
        int   exp_reads;
    } vec_t;

    systolic_array_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .k_len        (k_len),
        .abort        (abort),
        .arr_clear    (arr_clear),
        .op_rd_en     (op_rd_en),
        .op_rd_addr   (op_rd_addr),
        .a_lane_valid (a_lane_valid),
        .b_lane_valid (b_lane_valid),
        .res_capture  (res_capture),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_err     (done_err),
        .perf_cycles  (perf_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [13:0] act_vec();
        return {start_ready, busy, arr_clear, op_rd_en, a_lane_valid, b_lane_valid,
                res_capture, done_valid};
    endfunction

    // Expected outputs d cycles after the accept cycle, derived from the job latency table.
    function automatic logic [13:0] exp_vec(input int d, input int ke);
        logic [M-1:0] a;
        logic [N-1:0] b;
        for (int i = 0; i < M; i++) a[i] = (d >= 3 + i) && (d <= ke + 2 + i);
        for (int j = 0; j < N; j++) b[j] = (d >= 3 + j) && (d <= ke + 2 + j);
        return {1'b0, 1'b1, (d == 1), (d >= 2 && d <= ke + 1), a, b,
                (d == ke + M + N + 2), (d >= ke + M + N + 3)};
    endfunction

    task automatic start_job(input int k, input int exp_reads, input logic exp_err,
                             output int t, output bit ok);
        done_ready  = 1'b0;
        start_valid = 1'b1;
        k_len       = KW'(k);
        ok          = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 32'd1);
        t = cyc;
        if (ok) begin
            for (int a = 0; a < exp_reads; a++) addr_q.push_back(AW'(a));
            err_q.push_back(exp_err);
        end
    endtask

    task automatic run_job(input vec_t v, input bit keep, output int t, output int h);
        bit ok;
        int ds;
        int reads;
        start_job(v.k, v.exp_reads, v.exp_err, t, ok);
        h = t;
        if (!ok) return;
        ds    = v.exp_reads + M + N + 3;
        reads = 0;
        for (int d = 1; d <= ds + v.delay; d++) begin
            @(negedge clk);
            if (!keep) start_valid = 1'b0;
            check("out_vec", 32'(act_vec()), 32'(exp_vec(d, v.exp_reads)));
            if (op_rd_en) begin
                reads++;
                if (addr_q.size() == 0) check("rd_extra", 32'(op_rd_addr), 32'hffff_ffff);
                else check("rd_addr", 32'(op_rd_addr), 32'(addr_q.pop_front()));
            end
            if (d == ds + v.delay) begin
                if (err_q.size() == 0) check("done_extra", 32'(done_err), 32'hffff_ffff);
                else check("done_err", 32'(done_err), 32'(err_q.pop_front()));
            end
            done_ready = (d >= ds + v.delay);
        end
        h = cyc;
        @(negedge clk);
        done_ready = 1'b0;
        check("reads", 32'(reads), 32'(v.exp_reads));
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        check("idle_after", 32'({start_ready, busy}), 32'b10);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, 32'(h - t + 1));
`endif
    endtask

    vec_t tbl[7];
    int   t0, h0, t1, h1;
    bit   ok;
    bit   seen;

    initial begin
        tbl[0] = '{k: 3,   delay: 0, exp_err: 1'b0, exp_reads: 3};
        tbl[1] = '{k: 0,   delay: 0, exp_err: 1'b0, exp_reads: 0};
        tbl[2] = '{k: 1,   delay: 0, exp_err: 1'b0, exp_reads: 1};
        tbl[3] = '{k: 261, delay: 0, exp_err: 1'b1, exp_reads: 256};
        tbl[4] = '{k: 256, delay: 0, exp_err: 1'b0, exp_reads: 256};
        tbl[5] = '{k: 257, delay: 2, exp_err: 1'b1, exp_reads: 256};
        tbl[6] = '{k: 5,   delay: 3, exp_err: 1'b0, exp_reads: 5};

        rst = 1'b0; start_valid = 1'b0; k_len = '0; abort = 1'b0; done_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({act_vec(), done_err, op_rd_addr}), 32'd0);
        check("reset_perf", perf_cycles, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(act_vec()), 32'(IDLE_VEC));

        foreach (tbl[i]) run_job(tbl[i], 1'b0, t0, h0);

        // done held off 20 cycles with start_valid held high the whole time
        run_job('{k: 2, delay: 20, exp_err: 1'b0, exp_reads: 2}, 1'b1, t0, h0);
        run_job('{k: 4, delay: 0, exp_err: 1'b0, exp_reads: 4}, 1'b0, t1, h1);
        check("b2b_accept", 32'(t1), 32'(h0 + 1));
        start_valid = 1'b0;

        // abort in IDLE is ignored
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_abort", 32'(act_vec()), 32'(IDLE_VEC));
        end
        abort = 1'b0;

        // abort during FEED at addr 1
        start_job(5, 5, 1'b0, t0, ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_valid = 1'b0;
            if (op_rd_en && op_rd_addr == AW'(1)) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_addr1", 32'(ok), 32'd1);
        addr_q.delete();
        err_q.delete();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", 32'(act_vec()), 32'(IDLE_VEC | 14'b00_1000_0000_0000));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (op_rd_en || res_capture || done_valid || arr_clear || busy ||
                (a_lane_valid != '0) || (b_lane_valid != '0)) seen = 1'b1;
        end
        check("abort_quiet", 32'(seen), 32'd0);

        // reset asserted in DRAIN
        start_job(4, 4, 1'b0, t0, ok);
        repeat (8) @(negedge clk);
        start_valid = 1'b0;
        check("pre_reset_drain", 32'({busy, op_rd_en, arr_clear}), 32'b100);
        rst = 1'b0;
        @(negedge clk);
        check("midjob_reset_outs", 32'({act_vec(), done_err, op_rd_addr}), 32'd0);
        check("midjob_reset_perf", perf_cycles, 32'd0);
        addr_q.delete();
        err_q.delete();
        rst = 1'b1;
        #1;
        check("release_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        run_job('{k: 2, delay: 0, exp_err: 1'b0, exp_reads: 2}, 1'b0, t0, h0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("perf_k2", perf_cycles, 32'd14);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
